// File: rtl/hue_cycle_controller.sv
// Drives the RGB PWM channels around a 6-segment hue wheel from one shared PWM counter.
// Duties reload only on the last clk of a PWM period, so a period never changes duty midway.
module hue_cycle_controller #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned DUTY_STEP    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [2:0] segment,
  output logic       pwm_tick
);

  localparam int unsigned DUTY_W = $clog2(PWM_INTERVAL + 1);
  localparam int unsigned N      = PWM_INTERVAL / DUTY_STEP;
  localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;

  localparam logic [DUTY_W-1:0] MAX_DUTY = DUTY_W'(PWM_INTERVAL);
  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PWM_INTERVAL - 1);
  localparam logic [DUTY_W-1:0] STEP     = DUTY_W'(DUTY_STEP);
  localparam logic [KW-1:0]     LAST_K   = KW'(N - 1);

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [2:0]        seg_q, seg_d;
  logic [DUTY_W-1:0] ramp_q, ramp_d;
  logic [DUTY_W-1:0] duty_r_q, duty_r_d;
  logic [DUTY_W-1:0] duty_g_q, duty_g_d;
  logic [DUTY_W-1:0] duty_b_q, duty_b_d;
  logic              led_r_q, led_g_q, led_b_q;
  logic              tick;
  logic [DUTY_W-1:0] up, dn;

  always_comb begin
    tick     = enable && (cnt_q == LAST_CNT);
    cnt_d    = cnt_q;
    k_d      = k_q;
    seg_d    = seg_q;
    ramp_d   = ramp_q;
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    up       = '0;
    dn       = '0;

    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    if (tick) begin
      if (k_q == LAST_K) begin
        k_d    = '0;
        ramp_d = '0;
        seg_d  = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
      end else begin
        k_d    = k_q + 1'b1;
        ramp_d = ramp_q + STEP;
      end

      // ramp_d already equals k_next * DUTY_STEP, so no multiplier is needed
      up = ramp_d;
      dn = MAX_DUTY - ramp_d;
      unique case (seg_d)
        3'd0: begin duty_r_d = MAX_DUTY; duty_g_d = up;       duty_b_d = '0;       end
        3'd1: begin duty_r_d = dn;       duty_g_d = MAX_DUTY; duty_b_d = '0;       end
        3'd2: begin duty_r_d = '0;       duty_g_d = MAX_DUTY; duty_b_d = up;       end
        3'd3: begin duty_r_d = '0;       duty_g_d = dn;       duty_b_d = MAX_DUTY; end
        3'd4: begin duty_r_d = up;       duty_g_d = '0;       duty_b_d = MAX_DUTY; end
        3'd5: begin duty_r_d = MAX_DUTY; duty_g_d = '0;       duty_b_d = dn;       end
        default: begin duty_r_d = MAX_DUTY; duty_g_d = '0; duty_b_d = '0; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      k_q      <= '0;
      seg_q    <= '0;
      ramp_q   <= '0;
      duty_r_q <= MAX_DUTY;
      duty_g_q <= '0;
      duty_b_q <= '0;
      led_r_q  <= 1'b0;
      led_g_q  <= 1'b0;
      led_b_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      seg_q    <= seg_d;
      ramp_q   <= ramp_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
      led_r_q  <= enable && (cnt_q < duty_r_q);
      led_g_q  <= enable && (cnt_q < duty_g_q);
      led_b_q  <= enable && (cnt_q < duty_b_q);
    end
  end

  assign led_r    = led_r_q;
  assign led_g    = led_g_q;
  assign led_b    = led_b_q;
  assign segment  = seg_q;
  assign pwm_tick = tick;

endmodule

// File: tb/tb_hue_cycle_controller.sv
// Directed bench: a ramping instance (8/2) and a hard-switching instance (8/8) driven together.
module tb_hue_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       m_r, m_g, m_b, m_tick;
  logic [2:0] m_seg;
  logic       d_r, d_g, d_b, d_tick;
  logic [2:0] d_seg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hue_cycle_controller #(.PWM_INTERVAL(8), .DUTY_STEP(2)) dut_m (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .led_r   (m_r),
    .led_g   (m_g),
    .led_b   (m_b),
    .segment (m_seg),
    .pwm_tick(m_tick)
  );

  hue_cycle_controller #(.PWM_INTERVAL(8), .DUTY_STEP(8)) dut_d (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .led_r   (d_r),
    .led_g   (d_g),
    .led_b   (d_b),
    .segment (d_seg),
    .pwm_tick(d_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hue table with MAX = 8: ch 0=R 1=G 2=B
  function automatic int exp_duty(input int seg, input int up, input int ch);
    int dn;
    dn = 8 - up;
    case (seg)
      0: exp_duty = (ch == 0) ? 8  : (ch == 1) ? up : 0;
      1: exp_duty = (ch == 0) ? dn : (ch == 1) ? 8  : 0;
      2: exp_duty = (ch == 0) ? 0  : (ch == 1) ? 8  : up;
      3: exp_duty = (ch == 0) ? 0  : (ch == 1) ? dn : 8;
      4: exp_duty = (ch == 0) ? up : (ch == 1) ? 0  : 8;
      default: exp_duty = (ch == 0) ? 8 : (ch == 1) ? 0 : dn;
    endcase
  endfunction

  // Samples one 8-clk LED window (aligned one clk after the counter period) and checks it
  // as absolute period index p since the last reset release.
  task automatic run_period(input int p);
    int mr, mg, mb, dr, dg, db, m_bad, d_bad;
    logic [2:0] ms, ds;
    int seg, k;
    mr = 0; mg = 0; mb = 0; dr = 0; dg = 0; db = 0; m_bad = 0; d_bad = 0;
    ms = '0; ds = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ms = m_seg;
        ds = d_seg;
      end
      mr += int'(m_r); mg += int'(m_g); mb += int'(m_b);
      dr += int'(d_r); dg += int'(d_g); db += int'(d_b);
      if (m_tick !== (i == 6)) m_bad++;
      if (d_tick !== (i == 6)) d_bad++;
    end
    seg = (p / 4) % 6;
    k   = p % 4;
    check($sformatf("m_seg p%0d", p), 32'(ms), 32'(seg));
    check($sformatf("m_r p%0d", p), 32'(mr), 32'(exp_duty(seg, 2 * k, 0)));
    check($sformatf("m_g p%0d", p), 32'(mg), 32'(exp_duty(seg, 2 * k, 1)));
    check($sformatf("m_b p%0d", p), 32'(mb), 32'(exp_duty(seg, 2 * k, 2)));
    check($sformatf("m_tick p%0d", p), 32'(m_bad), 32'd0);
    seg = p % 6;
    check($sformatf("d_seg p%0d", p), 32'(ds), 32'(seg));
    check($sformatf("d_r p%0d", p), 32'(dr), 32'(exp_duty(seg, 0, 0)));
    check($sformatf("d_g p%0d", p), 32'(dg), 32'(exp_duty(seg, 0, 1)));
    check($sformatf("d_b p%0d", p), 32'(db), 32'(exp_duty(seg, 0, 2)));
    check($sformatf("d_tick p%0d", p), 32'(d_bad), 32'd0);
  endtask

  initial begin
    int leds, ticks, gc, bc;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("rst leds", {29'd0, m_r, m_g, m_b}, 32'd0);
    check("rst seg", 32'(m_seg), 32'd0);
    check("rst tick", 32'(m_tick), 32'd0);

    // Run into segment 1 (ramp) / segment 4 (hard), then reset mid-period
    rst    = 1'b0;
    enable = 1'b1;
    repeat (37) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst leds", {29'd0, m_r, m_g, m_b}, 32'd0);
    check("midrst seg", 32'(m_seg), 32'd0);
    check("midrst d_seg", 32'(d_seg), 32'd0);
    check("midrst d_leds", {29'd0, d_r, d_g, d_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full wheel plus one period: ramps, hard switching, wrap back to reset duties
    for (int p = 0; p < 25; p++) run_period(p);

    // Advance to cnt==3 of period 33 (segment 2, k 1) and freeze
    repeat (67) @(negedge clk);
    check("pre-pause seg", 32'(m_seg), 32'd2);
    enable = 1'b0;
    leds   = 0;
    ticks  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      leds  += int'(m_r) + int'(m_g) + int'(m_b) + int'(d_r) + int'(d_g) + int'(d_b);
      ticks += int'(m_tick) + int'(d_tick);
    end
    check("pause leds", 32'(leds), 32'd0);
    check("pause ticks", 32'(ticks), 32'd0);
    check("pause seg", 32'(m_seg), 32'd2);

    // Resume from frozen cnt=3: tick on the 4th sample, period wraps on the 5th clk
    enable = 1'b1;
    gc     = 0;
    bc     = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i <= 4) check($sformatf("resume tick %0d", i), 32'(m_tick), 32'(i == 4));
      gc += int'(m_g);
      bc += int'(m_b);
    end
    check("resume tail g", 32'(gc), 32'd5);
    check("resume tail b", 32'(bc), 32'd0);
    for (int p = 34; p < 37; p++) run_period(p);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
